// File: rtl/ps2_keyboard_decoder.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: two-flop sync, ps2_clk glitch filter, 11-bit frame check, set-2 arrow key tracking.
// rx_valid/rx_err one clk after the stop-bit sample event; arrow levels one clk after that strobe.
module ps2_keyboard_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          clk_s, dat_s, sample;

  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    rx_byte_q;
  logic          rx_valid_q, rx_err_q;

  logic          ext_q, brk_q;
  logic          up_q, down_q, left_q, right_q;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Lines idle high, so the synchronizers and filter come out of reset high to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_filt_q <= clk_filt_d;
      flt_cnt_q  <= flt_cnt_d;
    end
  end

  always_comb begin
    clk_filt_d = clk_filt_q;
    flt_cnt_d  = '0;
    if (clk_s != clk_filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign sample = clk_filt_q && !clk_filt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (sample) begin
        to_cnt_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dat_s) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end
          end
          DATA: begin
            shift_q  <= {dat_s, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat_s;
            state_q <= STOP;
          end
          STOP: begin
            if (dat_s && (^{shift_q, par_q})) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        // A sample event in the same cycle wins over the timeout.
        if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q  <= IDLE;
          rx_err_q <= 1'b1;
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else if (rx_err_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (rx_valid_q) begin
      if (rx_byte_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else begin
        if (ext_q) begin
          case (rx_byte_q)
            8'h75:   up_q    <= ~brk_q;
            8'h72:   down_q  <= ~brk_q;
            8'h6B:   left_q  <= ~brk_q;
            8'h74:   right_q <= ~brk_q;
            default: ;
          endcase
        end
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign up       = up_q;
  assign down     = down_q;
  assign left     = left_q;
  assign right    = right_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
`timescale 1ns/1ps
// Bench for ps2_keyboard_decoder: frame driver plus byte-level key model feeding a scoreboard queue.
module tb_ps2_keyboard_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 1000;
  localparam int HP   = 200;   // PS/2 half-period in ns (20 clk cycles)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up, down, left, right, rx_valid, rx_err;
  logic [7:0] rx_byte;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
    logic [3:0] keys;   // {right, left, down, up}
  } exp_t;

  exp_t       q[$];
  logic       m_ext, m_brk;
  logic [3:0] m_keys;
  logic [7:0] m_last;

  ps2_keyboard_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key state as a function of the received byte stream: prefixes accumulate,
  // the next plain byte resolves them.
  function automatic void model(input bit err, input logic [7:0] b);
    exp_t e;
    int   idx;
    if (err) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_last = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        idx = (b == 8'h75) ? 0 : (b == 8'h72) ? 1 : (b == 8'h6B) ? 2 : (b == 8'h74) ? 3 : -1;
        if (m_ext && idx >= 0) m_keys[idx] = !m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    e.err  = err;
    e.b    = m_last;
    e.keys = m_keys;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_keys = '0;
    m_last = '0;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      #(HP/2); ps2_data = bits[i];
      #(HP/2); ps2_clk = 1'b0;
      #(HP);   ps2_clk = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    model(bad_par | bad_stop, b);
    send_bits(f, 11);
    #(HP/2); ps2_data = 1'b1;
    #(HP);
  endtask

  // Monitor: pops one expectation per strobe, checks key levels the cycle after.
  exp_t cur;
  bit   key_chk = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      key_chk = 1'b0;
    end else begin
      if (key_chk) begin
        check("keys", {right, left, down, up}, cur.keys);
        key_chk = 1'b0;
      end
      if (rx_valid || rx_err) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: valid=%0b err=%0b byte=%0h, none expected", rx_valid, rx_err, rx_byte);
        end else begin
          cur = q.pop_front();
          check("strobe_is_err", rx_err, cur.err);
          check("strobe_excl", rx_valid & rx_err, 0);
          check("rx_byte", rx_byte, cur.b);
          key_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation did not finish, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [7:0] arrows [4];
    arrows[0] = 8'h75; arrows[1] = 8'h72; arrows[2] = 8'h6B; arrows[3] = 8'h74;
    model_reset();

    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", {up, down, left, right, rx_valid, rx_err, rx_byte}, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // up make then break
    send(8'hE0); send(8'h75);
    check("up_made", {right, left, down, up}, 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_broken", {right, left, down, up}, 4'b0000);

    // bad parity after E0 clears the prefix, so the next 75 is the keypad key
    send(8'hE0); send(8'h75, 1'b1); send(8'h75);
    check("up_after_bad_parity", up, 0);

    // left and right together
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
    check("left_right", {right, left, down, up}, 4'b1100);

    // mid-frame timeout
    model(1'b1, 8'h00);
    send_bits(11'b000_0001_1010, 5);
    n = 0;
    while (!rx_err && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("timeout_window", (n >= TMO - HP/10 - 15) && (n <= TMO - HP/10 + 25), 1);
    repeat (1200 - n) @(posedge clk);
    send(8'hE0); send(8'h72);
    check("down_after_timeout", down, 1);

    // short glitch while idle must not start a frame
    ps2_data = 1'b0;
    @(posedge clk); ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h1C);

    // randomized byte streams
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: send(8'hE0);
        3:       send(8'hF0);
        4, 5, 6: send(arrows[$urandom_range(0, 3)]);
        7:       send(8'($urandom));
        8:       send(arrows[$urandom_range(0, 3)], 1'b1, 1'b0);
        default: send(8'($urandom), 1'b0, 1'b1);
      endcase
    end
    send(8'h00);

    // reset in the middle of a frame with a key held
    send(8'hE0); send(8'h6B);
    check("left_before_reset", left, 1);
    send_bits(11'b000_0000_0010, 4);
    reset = 1'b1;
    #1;
    check("reset_midframe_outputs", {up, down, left, right, rx_valid, rx_err, rx_byte}, 0);
    model_reset();
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    send(8'hE0); send(8'h6B);
    check("left_after_reset", {right, left, down, up}, 4'b0100);

    repeat (50) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
